// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: funct3 codes, FSM states and bundle sizing
// shared by the integer execute unit.
package alu_exec_pkg;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // a, b, funct3, alt, mul, tag
  function automatic int op_w(input int xlen, input int tag_w);
    return 2 * xlen + 3 + 1 + 1 + tag_w;
  endfunction

endpackage

// File: rtl/alu_exec_mul.sv
// alu_exec_mul: iterative shift-add multiplier, one bit of b
// per cycle; bit 0 is folded into the start cycle.
module alu_exec_mul #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(XLEN);

  logic            run;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;

  assign done    = run && (cnt == CW'(XLEN - 1));
  assign product = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run    <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= CW'(1);
      acc    <= b[0] ? a : '0;
      mcand  <= a << 1;
      mplier <= b >> 1;
    end else if (run) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered RV32I ALU with tagged valid/ready ports.
// Iterative multiplier is built only when ALU_EXEC_MUL_EN is defined.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [2:0]       in_funct3,
  input  logic             in_alt,
  input  logic             in_mul,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_zero,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int SHW = $clog2(XLEN);

  logic             out_free;
  logic             accept;
  logic             ld_alu;
  logic             ld_err;
  logic             ld_mul;
  logic [SHW-1:0]   shamt;
  logic [XLEN-1:0]  sra_res;
  logic [XLEN-1:0]  alu_res;
  logic [XLEN-1:0]  mul_res;
  logic [TAG_W-1:0] mul_tag;

  assign out_free = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign ld_alu   = accept && !in_mul;
  assign shamt    = in_b[SHW-1:0];
  assign sra_res  = $signed(in_a) >>> shamt;

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      (in_funct3 == F3_ADD):
        alu_res = in_alt ? in_a - in_b : in_a + in_b;
      (in_funct3 == F3_SLL):
        alu_res = in_a << shamt;
      (in_funct3 == F3_SLT):
        alu_res = {{(XLEN-1){1'b0}},
                   $signed(in_a) < $signed(in_b)};
      (in_funct3 == F3_SLTU):
        alu_res = {{(XLEN-1){1'b0}}, in_a < in_b};
      (in_funct3 == F3_XOR):
        alu_res = in_a ^ in_b;
      (in_funct3 == F3_SR):
        alu_res = in_alt ? sra_res : in_a >> shamt;
      (in_funct3 == F3_OR):
        alu_res = in_a | in_b;
      (in_funct3 == F3_AND):
        alu_res = in_a & in_b;
      default:
        alu_res = '0;
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  state_t state;
  state_t state_nx;
  logic   mul_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (accept && in_mul) state_nx = ST_MUL;
      ST_MUL:  if (mul_done) state_nx = ST_DONE;
      ST_DONE: if (out_free) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  mul_tag <= '0;
    else if (accept && in_mul) mul_tag <= in_tag;
  end

  assign in_ready = (state == ST_IDLE) && out_free;
  assign busy     = (state != ST_IDLE);
  assign ld_mul   = (state == ST_DONE) && out_free;
  assign ld_err   = 1'b0;

  alu_exec_mul #(.XLEN(XLEN)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && in_mul),
    .a       (in_a),
    .b       (in_b),
    .done    (mul_done),
    .product (mul_res)
  );
`else
  assign in_ready = out_free;
  assign busy     = 1'b0;
  assign ld_mul   = 1'b0;
  assign ld_err   = accept && in_mul;
  assign mul_res  = '0;
  assign mul_tag  = '0;
`endif

  // One-entry output register; a new load may coincide with consumption.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_err    <= 1'b0;
      out_tag    <= '0;
    end else if (ld_alu) begin
      out_valid  <= 1'b1;
      out_result <= alu_res;
      out_zero   <= (alu_res == '0);
      out_err    <= 1'b0;
      out_tag    <= in_tag;
    end else if (ld_err) begin
      out_valid  <= 1'b1;
      out_result <= '0;
      out_zero   <= 1'b1;
      out_err    <= 1'b1;
      out_tag    <= in_tag;
    end else if (ld_mul) begin
      out_valid  <= 1'b1;
      out_result <= mul_res;
      out_zero   <= (mul_res == '0);
      out_err    <= 1'b0;
      out_tag    <= mul_tag;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
